// File: rtl/pwm_pkg.sv
// Shared sizing defaults and the time/edge value type for the PWM output stage.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;

    typedef logic [PWM_WIDTH-1:0] time_t;

endpackage

// File: rtl/pwm_if.sv
// Bundle of the per-channel time/edge inputs, the capture strobe and the PWM status outputs.
interface pwm_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = PWM_DEPTH
);

    logic [WIDTH-1:0] TIME [DEPTH];
    logic [WIDTH-1:0] RISE [DEPTH];
    logic [WIDTH-1:0] FALL [DEPTH];
    logic             DONE;
    logic [DEPTH-1:0] PWM_OUT;
    logic             PENDING;

    modport master (
        output TIME,
        output RISE,
        output FALL,
        output DONE,
        input  PWM_OUT,
        input  PENDING
    );

    modport slave (
        input  TIME,
        input  RISE,
        input  FALL,
        input  DONE,
        output PWM_OUT,
        output PENDING
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: holds the committed edges, swaps in the shadow edges at its own
// period wrap, and registers the window comparison of its time counter.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] time_val,
    input  logic [WIDTH-1:0] shadow_rise,
    input  logic [WIDTH-1:0] shadow_fall,
    input  logic             capture,
    output logic             pend,
    output logic             pwm
);

    logic [WIDTH-1:0] active_rise;
    logic [WIDTH-1:0] active_fall;
    logic [WIDTH-1:0] next_rise;
    logic [WIDTH-1:0] next_fall;
    logic             commit;
    logic             window;

    // The period that starts at TIME=0 must already see the freshly committed edges,
    // so the comparison uses the post-commit values rather than the active registers.
    always_comb begin
        commit    = pend && (time_val == '0);
        next_rise = commit ? shadow_rise : active_rise;
        next_fall = commit ? shadow_fall : active_fall;
        window    = 1'b0;
        if (next_rise < next_fall) begin
            window = (time_val >= next_rise) && (time_val < next_fall);
        end else if (next_rise > next_fall) begin
            window = (time_val >= next_rise) || (time_val < next_fall);
        end
    end

    // A capture on the commit edge wins the pend flag: the shadow now holds newer
    // edges than the ones being committed, so they must wait for the next wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_rise <= '0;
            active_fall <= '0;
            pend        <= 1'b0;
            pwm         <= 1'b0;
        end else begin
            if (commit) begin
                active_rise <= next_rise;
                active_fall <= next_fall;
            end
            if (capture) begin
                pend <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
            pwm <= window;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Per-transducer PWM output stage: captures RISE/FALL into shadow registers on DONE and
// lets every channel commit them at its own period boundary.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = PWM_DEPTH
) (
    input  logic CLK,
    input  logic RST_N,
    pwm_if.slave bus
);

    logic [WIDTH-1:0] shadow_rise [DEPTH];
    logic [WIDTH-1:0] shadow_fall [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pwm_bits;
    logic             pending_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_chan

        // The shadow always takes the newest published edges; a second DONE before
        // the commit simply overwrites the first.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                shadow_rise[g] <= '0;
                shadow_fall[g] <= '0;
            end else if (bus.DONE) begin
                shadow_rise[g] <= bus.RISE[g];
                shadow_fall[g] <= bus.FALL[g];
            end
        end

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk         (CLK),
            .rst_n       (RST_N),
            .time_val    (bus.TIME[g]),
            .shadow_rise (shadow_rise[g]),
            .shadow_fall (shadow_fall[g]),
            .capture     (bus.DONE),
            .pend        (pend[g]),
            .pwm         (pwm_bits[g])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= |pend;
        end
    end

    assign bus.PWM_OUT = pwm_bits;
    assign bus.PENDING = pending_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: a vector table, directed period sequences and
// random multi-rate traffic, all compared every cycle against a per-channel edge model.
module tb_pwm_generator;
    import pwm_pkg::*;

    localparam int DEPTH = PWM_DEPTH;

    typedef struct {
        time_t rise;
        time_t fall;
        time_t t;
        logic  high;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pwm_if bus ();

    pwm_generator dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    time_t tcnt [DEPTH];
    int    cyc  [DEPTH];

    time_t m_shadow_rise [DEPTH];
    time_t m_shadow_fall [DEPTH];
    time_t m_active_rise [DEPTH];
    time_t m_active_fall [DEPTH];
    logic  m_pend        [DEPTH];
    logic [DEPTH-1:0] exp_pwm;
    logic             exp_pending;

    int   cnt_hi0;
    int   cnt_plow;
    int   cnt_any;
    logic hist0 [8192];
    logic phist [8192];

    vec_t vecs [17];

    function automatic logic in_window(time_t r, time_t f, time_t t);
        if (r < f) return (t >= r) && (t < f);
        if (r > f) return (t >= r) || (t < f);
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_shadow_rise[i] = '0;
            m_shadow_fall[i] = '0;
            m_active_rise[i] = '0;
            m_active_fall[i] = '0;
            m_pend[i]        = 1'b0;
        end
        exp_pwm     = '0;
        exp_pending = 1'b0;
    endtask

    // Reference behaviour for one clock edge, using the inputs the bench is driving.
    task automatic model_edge();
        logic any_pend;
        logic wrap;
        if (!rst_n) begin
            model_clear();
            return;
        end
        any_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_pend = any_pend | m_pend[i];
        exp_pending = any_pend;
        for (int i = 0; i < DEPTH; i++) begin
            wrap = m_pend[i] && (bus.TIME[i] == '0);
            if (wrap) begin
                m_active_rise[i] = m_shadow_rise[i];
                m_active_fall[i] = m_shadow_fall[i];
            end
            exp_pwm[i] = in_window(m_active_rise[i], m_active_fall[i], bus.TIME[i]);
            if (bus.DONE) begin
                m_shadow_rise[i] = bus.RISE[i];
                m_shadow_fall[i] = bus.FALL[i];
                m_pend[i]        = 1'b1;
            end else if (wrap) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic check_output(input string name, input logic [DEPTH-1:0] act,
                                input logic [DEPTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h want %h", name, $time, act, req);
        end
    endtask

    task automatic check_value(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d want %0d", name, $time, act, req);
        end
    endtask

    task automatic clear_stats();
        cnt_hi0  = 0;
        cnt_plow = 0;
        cnt_any  = 0;
        for (int i = 0; i < 8192; i++) begin
            hist0[i] = 1'b0;
            phist[i] = 1'b0;
        end
    endtask

    // One clock: drive TIME/DONE, take the edge, compare against the model, advance counters.
    task automatic apply_stimulus(input logic done);
        bus.DONE = done;
        for (int i = 0; i < DEPTH; i++) bus.TIME[i] = tcnt[i];
        @(posedge clk);
        model_edge();
        #1;
        check_output("pwm_out", bus.PWM_OUT, exp_pwm);
        check_value("pending", int'(bus.PENDING), int'(exp_pending));
        if (bus.PWM_OUT[0]) cnt_hi0++;
        if (!bus.PENDING) cnt_plow++;
        if ((|bus.PWM_OUT) || bus.PENDING) cnt_any++;
        hist0[bus.TIME[0]] = bus.PWM_OUT[0];
        phist[bus.TIME[0]] = bus.PENDING;
        for (int i = 0; i < DEPTH; i++) tcnt[i] = time_t'((int'(tcnt[i]) + 1) % cyc[i]);
        bus.DONE = 1'b0;
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0);
    endtask

    task automatic do_done(input time_t r, input time_t f);
        for (int i = 0; i < DEPTH; i++) begin
            bus.RISE[i] = r;
            bus.FALL[i] = f;
        end
        apply_stimulus(1'b1);
    endtask

    task automatic set_uniform(input int c, input time_t t);
        for (int i = 0; i < DEPTH; i++) begin
            cyc[i]  = c;
            tcnt[i] = t;
        end
    endtask

    // Asserts reset between clock edges so the asynchronous clear is observed on its own.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_pwm_async", bus.PWM_OUT, '0);
        check_value("reset_pending_async", int'(bus.PENDING), 0);
        model_clear();
        repeat (3) apply_stimulus(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog at %0t: got timeout want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{13'd1024, 13'd3072, 13'd1023, 1'b0};
        vecs[1]  = '{13'd1024, 13'd3072, 13'd1024, 1'b1};
        vecs[2]  = '{13'd1024, 13'd3072, 13'd3071, 1'b1};
        vecs[3]  = '{13'd1024, 13'd3072, 13'd3072, 1'b0};
        vecs[4]  = '{13'd3072, 13'd1024, 13'd0,    1'b1};
        vecs[5]  = '{13'd3072, 13'd1024, 13'd1023, 1'b1};
        vecs[6]  = '{13'd3072, 13'd1024, 13'd1024, 1'b0};
        vecs[7]  = '{13'd3072, 13'd1024, 13'd3071, 1'b0};
        vecs[8]  = '{13'd3072, 13'd1024, 13'd3072, 1'b1};
        vecs[9]  = '{13'd3072, 13'd1024, 13'd4095, 1'b1};
        vecs[10] = '{13'd2048, 13'd2048, 13'd2048, 1'b0};
        vecs[11] = '{13'd2048, 13'd2048, 13'd0,    1'b0};
        vecs[12] = '{13'd0,    13'd100,  13'd0,    1'b1};
        vecs[13] = '{13'd0,    13'd100,  13'd100,  1'b0};
        vecs[14] = '{13'd0,    13'd8191, 13'd8190, 1'b1};
        vecs[15] = '{13'd8191, 13'd0,    13'd8191, 1'b1};
        vecs[16] = '{13'd8191, 13'd0,    13'd8190, 1'b0};

        bus.DONE = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.TIME[i] = '0;
            bus.RISE[i] = '0;
            bus.FALL[i] = '0;
        end
        set_uniform(8192, '0);
        model_clear();
        clear_stats();
        apply_reset();

        $display("[TB] window table");
        for (int k = 0; k < 17; k++) begin
            set_uniform(8192, 13'd5);
            do_done(vecs[k].rise, vecs[k].fall);
            set_uniform(8192, '0);
            apply_stimulus(1'b0);
            set_uniform(8192, vecs[k].t);
            apply_stimulus(1'b0);
            check_value($sformatf("table[%0d]", k), int'(bus.PWM_OUT[0]), int'(vecs[k].high));
        end

        apply_reset();
        set_uniform(4096, '0);

        $display("[TB] normal window");
        run_steps(100);
        do_done(13'd1024, 13'd3072);
        clear_stats();
        run_steps(3995);
        check_value("normal_hold_low", cnt_hi0, 0);
        check_value("normal_pending_held", cnt_plow, 0);

        clear_stats();
        run_steps(50);
        do_done(13'd3072, 13'd1024);
        run_steps(4045);
        check_value("normal_count", cnt_hi0, 2048);
        check_value("normal_t1023", int'(hist0[1023]), 0);
        check_value("normal_t1024", int'(hist0[1024]), 1);
        check_value("normal_t3071", int'(hist0[3071]), 1);
        check_value("normal_t3072", int'(hist0[3072]), 0);
        check_value("normal_pending_t0", int'(phist[0]), 1);
        check_value("normal_pending_fall", int'(phist[1]), 0);

        $display("[TB] wrapped and equal windows");
        clear_stats();
        run_steps(50);
        do_done(13'd2048, 13'd2048);
        run_steps(4045);
        check_value("wrap_count", cnt_hi0, 2048);
        check_value("wrap_t0", int'(hist0[0]), 1);
        check_value("wrap_t1023", int'(hist0[1023]), 1);
        check_value("wrap_t1024", int'(hist0[1024]), 0);
        check_value("wrap_t3071", int'(hist0[3071]), 0);
        check_value("wrap_t3072", int'(hist0[3072]), 1);
        check_value("wrap_t4095", int'(hist0[4095]), 1);

        clear_stats();
        run_steps(50);
        do_done(13'd1024, 13'd3072);
        run_steps(4045);
        check_value("equal_count", cnt_hi0, 0);

        $display("[TB] mid-period update");
        clear_stats();
        run_steps(2000);
        do_done(13'd0, 13'd2048);
        run_steps(2095);
        check_value("mid_keep_count", cnt_hi0, 2048);
        check_value("mid_keep_t2500", int'(hist0[2500]), 1);
        check_value("mid_keep_t3072", int'(hist0[3072]), 0);

        clear_stats();
        run_steps(2500);
        do_done(13'd100, 13'd200);
        run_steps(499);
        do_done(13'd512, 13'd1536);
        run_steps(1095);
        check_value("mid_new_count", cnt_hi0, 2048);
        check_value("mid_new_t0", int'(hist0[0]), 1);
        check_value("mid_new_t2047", int'(hist0[2047]), 1);
        check_value("mid_new_t2048", int'(hist0[2048]), 0);

        clear_stats();
        run_steps(4096);
        check_value("latest_count", cnt_hi0, 1024);
        check_value("latest_t100", int'(hist0[100]), 0);
        check_value("latest_t511", int'(hist0[511]), 0);
        check_value("latest_t512", int'(hist0[512]), 1);
        check_value("latest_t1535", int'(hist0[1535]), 1);
        check_value("latest_t1536", int'(hist0[1536]), 0);

        $display("[TB] DONE on the commit edge");
        run_steps(50);
        do_done(13'd1024, 13'd3072);
        run_steps(4045);
        clear_stats();
        do_done(13'd0, 13'd100);
        run_steps(4095);
        check_value("simul_count", cnt_hi0, 2048);
        check_value("simul_t0", int'(hist0[0]), 0);
        check_value("simul_t1024", int'(hist0[1024]), 1);
        check_value("simul_pending_held", cnt_plow, 0);

        clear_stats();
        run_steps(4096);
        check_value("simul_next_count", cnt_hi0, 100);
        check_value("simul_next_t0", int'(hist0[0]), 1);
        check_value("simul_next_t99", int'(hist0[99]), 1);
        check_value("simul_next_t100", int'(hist0[100]), 0);
        check_value("simul_pending_t0", int'(phist[0]), 1);
        check_value("simul_pending_fall", int'(phist[1]), 0);

        $display("[TB] reset mid-period");
        run_steps(51);
        check_value("pre_reset_high", int'(bus.PWM_OUT[0]), 1);
        apply_reset();
        set_uniform(4096, '0);
        clear_stats();
        run_steps(8192);
        check_value("post_reset_quiet", cnt_any, 0);

        $display("[TB] independent periods and random traffic");
        for (int i = 0; i < DEPTH; i++) begin
            cyc[i]  = int'($urandom_range(16, 8192));
            tcnt[i] = time_t'($urandom_range(0, cyc[i] - 1));
        end
        cyc[0]  = 4096;
        tcnt[0] = 13'd10;
        cyc[1]  = 2000;
        tcnt[1] = 13'd1990;
        do_done(13'd0, 13'd5);
        run_steps(9);
        apply_stimulus(1'b0);
        check_value("indep_ch1_commit", int'(bus.PWM_OUT[1]), 1);
        check_value("indep_ch0_waits", int'(bus.PWM_OUT[0]), 0);
        run_steps(4075);
        apply_stimulus(1'b0);
        check_value("indep_ch0_commit", int'(bus.PWM_OUT[0]), 1);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bus.RISE[i] = time_t'($urandom_range(0, cyc[i] - 1));
                    bus.FALL[i] = time_t'($urandom_range(0, cyc[i] - 1));
                end
                apply_stimulus(1'b1);
            end else begin
                apply_stimulus(1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
